// File: rtl/aes_round_engine.sv
// Iterative AES cipher/inverse-cipher core, one round per clock.
// Round keys arrive pre-expanded on a flat bus, key 0 first.
module aes_round_engine #(
  parameter int NK = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     decrypt,
  input  logic [0:127]             din,
  input  logic [0:128*(NK+7)-1]    round_keys,
  output logic                     busy,
  output logic                     done,
  output logic [0:127]             dout
);

  localparam int NR = NK + 6;

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_round_engine: NK must be 4, 6 or 8");
  end

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse table is derived from the forward one at elaboration.
  function automatic logic [0:2047] inv_tab(input logic [0:2047] t);
    logic [0:2047] r;
    r = '0;
    for (int i = 0; i < 256; i++)
      r[{t[8*i +: 8], 3'b000} +: 8] = 8'(i);
    return r;
  endfunction

  localparam logic [0:2047] ISBOX = inv_tab(SBOX);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [3:0] m
  );
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  function automatic logic [0:127] sub_bytes(
    input logic [0:127] s,
    input logic         inv
  );
    logic [0:127] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = s[8*i +: 8];
      r[8*i +: 8] = inv ? ISBOX[{b, 3'b000} +: 8]
                        : SBOX[{b, 3'b000} +: 8];
    end
    return r;
  endfunction

  function automatic logic [0:127] shift_rows(
    input logic [0:127] s,
    input logic         inv
  );
    logic [0:127] r;
    int           src;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c - row + 4) % 4 : (c + row) % 4;
        r[8*(row+4*c) +: 8] = s[8*(row+4*src) +: 8];
      end
    return r;
  endfunction

  // Circulant matrix: row j uses coefficient (k-j) mod 4 for byte k.
  function automatic logic [0:127] mix_cols(
    input logic [0:127] s,
    input logic         inv
  );
    logic [0:127] r;
    logic [15:0]  cf;
    int           ci;
    r  = '0;
    cf = inv ? 16'hebd9 : 16'h2311;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++) begin
          ci = (k - j + 4) % 4;
          r[8*(4*c+j) +: 8] = r[8*(4*c+j) +: 8] ^
            gmul(s[8*(4*c+k) +: 8], cf[15-4*ci -: 4]);
        end
    return r;
  endfunction

  state_e       state_q;
  state_e       state_d;
  logic [0:127] st_q;
  logic [3:0]   rnd_q;
  logic         mode_q;
  logic [0:127] dout_q;
  logic         done_q;

  logic [3:0]   kidx;
  logic [10:0]  kbase;
  logic [0:127] rk;
  logic         last;
  logic [0:127] enc_t;
  logic [0:127] dec_t;
  logic [0:127] nxt;
  logic [0:127] init;

  assign kidx  = mode_q ? 4'(NR) - rnd_q : rnd_q;
  assign kbase = {kidx, 7'b0};
  assign rk    = round_keys[kbase +: 128];
  assign last  = (rnd_q == 4'(NR));

  assign init = din ^ (decrypt ? round_keys[128*NR +: 128]
                               : round_keys[0 +: 128]);

  always_comb begin
    enc_t = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
    if (!last) enc_t = mix_cols(enc_t, 1'b0);
    enc_t = enc_t ^ rk;
    dec_t = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ rk;
    if (!last) dec_t = mix_cols(dec_t, 1'b1);
    nxt = mode_q ? dec_t : enc_t;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (last)  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
      mode_q  <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            st_q   <= init;
            mode_q <= decrypt;
            rnd_q  <= 4'd1;
          end
        end
        S_RUN: begin
          st_q  <= nxt;
          rnd_q <= last ? 4'd0 : rnd_q + 4'd1;
          if (last) begin
            dout_q <= nxt;
            done_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign dout = dout_q;

endmodule
